// File: rtl/edge_propagator_tx_multi_if.sv
// edge_propagator_tx_multi_if: per-channel event, request/ack and status bundle
// master drives events/acks/clears; slave is the transmitter
interface edge_propagator_tx_multi_if #(
  parameter int NumChannels = 1,
  parameter int CntWidth = 2
);
  logic [NumChannels-1:0] valid_i;
  logic [NumChannels-1:0] ack_i;
  logic [NumChannels-1:0] clr_ovf_i;
  logic [NumChannels-1:0] valid_o;
  logic [NumChannels-1:0] busy_o;
  logic [NumChannels-1:0] overflow_o;
  logic [NumChannels*CntWidth-1:0] pending_o;
  modport master (
    output valid_i, ack_i, clr_ovf_i,
    input valid_o, busy_o, overflow_o, pending_o
  );
  modport slave (
    input valid_i, ack_i, clr_ovf_i,
    output valid_o, busy_o, overflow_o, pending_o
  );
endinterface

// File: rtl/edge_propagator_tx_multi.sv
// edge_propagator_tx_multi: multi-channel 4-phase CDC event transmitter with replay counters
// Define EDGE_PROP_TX_OVF_EN to enable the sticky overflow_o flag.
module edge_propagator_tx_multi #(
  parameter int NumChannels = 1,
  parameter int SyncStages = 2,
  parameter int CntWidth = 2
) (
  input logic clk_i,
  input logic rstn_i,
  edge_propagator_tx_multi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACKLOW} state_t;
  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    state_t state_q, state_d;
    logic [SyncStages-1:0] sync_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic req_q, ack_sync, pend, launch, inc, dec, ovf_evt;
    assign ack_sync = sync_q[SyncStages-1];
    always_comb begin
      pend = cnt_q != '0;
      launch = state_q == IDLE && (bus.valid_i[c] || pend);
      dec = launch && pend;
      // an event that launches straight from an empty counter is never stored
      inc = bus.valid_i[c] && !(launch && !pend);
      ovf_evt = inc && !dec && cnt_q == CntMax;
      cnt_d = (inc == dec || ovf_evt) ? cnt_q : inc ? cnt_q + CntOne : cnt_q - CntOne;
      state_d = state_q == IDLE ? (launch ? REQ : IDLE) :
                state_q == REQ ? (ack_sync ? ACKLOW : REQ) :
                (ack_sync ? ACKLOW : IDLE);
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sync_q <= '0;
        state_q <= IDLE;
        cnt_q <= '0;
        req_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SyncStages-2:0], bus.ack_i[c]};
        state_q <= state_d;
        cnt_q <= cnt_d;
        req_q <= state_d == REQ;
      end
    end
    assign bus.valid_o[c] = req_q;
    assign bus.busy_o[c] = state_q != IDLE || pend;
    assign bus.pending_o[c*CntWidth +: CntWidth] = cnt_q;
`ifdef EDGE_PROP_TX_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) ovf_q <= 1'b0;
      else ovf_q <= ovf_evt ? 1'b1 : bus.clr_ovf_i[c] ? 1'b0 : ovf_q;
    end
    assign bus.overflow_o[c] = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_evt ^ bus.clr_ovf_i[c];
    assign bus.overflow_o[c] = 1'b0;
`endif
  end
endmodule
